gf_pow_engine: RTL and testbench

- Sequential exponentiation engine over GF(2^N) in polynomial basis: computes y = x^e, with e supplied per transaction, by MSB-first square-and-multiply.
- Generalised successor to the fixed-exponent, fixed-width combinational power-map S-boxes in this codebase: field width, reduction polynomial and exponent width are parameters.
- Valid/ready handshakes on input and output; sits between a stimulus or key-schedule source and S-box/inversion consumers.

---
 rtl/gf_pow_engine_if.sv | 24 ++
 rtl/gf_pow_engine.sv | 100 ++++++++++
 tb/tb_gf_pow_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gf_pow_engine_if.sv
// Operand/result handshake bundle for the GF(2^N) exponentiation engine.
// The master is the operand source and result consumer; the slave is the engine.
interface gf_pow_engine_if #(
    parameter int N     = 6,
    parameter int EXP_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     x;
    logic [EXP_W-1:0] e;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     y;

    modport master (
        output in_valid, x, e, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, e, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/gf_pow_engine.sv
// Sequential y = x^e over GF(2^N), polynomial basis, MSB-first square-and-multiply.
// One exponent bit per cycle: EXP_W RUN cycles per operation, regardless of e.
module gf_pow_engine #(
    parameter int         N     = 6,
    parameter logic [N:0] POLY  = 7'b1000011,
    parameter int         EXP_W = 6
) (
    input logic           clk,
    input logic           rst,
    gf_pow_engine_if.slave bus
);
    localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXP_W - 1);

    if (POLY[N] != 1'b1) begin : g_poly_check
        $error("gf_pow_engine: POLY[N] must be 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [N-1:0]     acc, base, y_r;
    logic [EXP_W-1:0] exp_r;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     sq, acc_next;
    logic             in_ready_c, out_valid_c;

    // Shift-and-add product with the reduction folded into each shift step.
    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            r = r[N-1] ? ((r << 1) ^ POLY[N-1:0]) : (r << 1);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    always_comb begin
        sq       = gf_mul(acc, acc);
        acc_next = exp_r[count] ? gf_mul(sq, base) : sq;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = RUN;
            end
            RUN: begin
                if (count == '0) state_next = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            base  <= '0;
            exp_r <= '0;
            count <= '0;
            y_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        base  <= bus.x;
                        exp_r <= bus.e;
                        acc   <= N'(1);
                        count <= CNT_LAST;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (count == '0) y_r <= acc_next;
                    else             count <= count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.y         = y_r;
endmodule

// File: tb/tb_gf_pow_engine.sv
// Bench for gf_pow_engine: vector table, hand-written corner sequences and a
// scoreboard-checked random run on the default field, plus an 8-bit AES-field instance.
module tb_gf_pow_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gf_pow_engine_if #(.N(6), .EXP_W(6)) b6 ();
    gf_pow_engine_if #(.N(8), .EXP_W(8)) b8 ();

    gf_pow_engine #(.N(6), .POLY(7'b1000011), .EXP_W(6)) dut6 (
        .clk(clk), .rst(rst), .bus(b6.slave)
    );
    gf_pow_engine #(.N(8), .POLY(9'h11B), .EXP_W(8)) dut8 (
        .clk(clk), .rst(rst), .bus(b8.slave)
    );

    typedef struct {
        logic [5:0] x;
        logic [5:0] e;
        logic [5:0] y;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned sb[$];
    vec_t        vt[7];
    bit          drv_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Independent reference: full carry-less product, then long division by poly.
    function automatic int unsigned gmul(input int unsigned a, input int unsigned b,
                                         input int n, input int unsigned poly);
        int unsigned p = 0;
        for (int i = 0; i < n; i++) if (b[i]) p ^= a << i;
        for (int bt = 2 * n - 2; bt >= n; bt--) if (p[bt]) p ^= poly << (bt - n);
        return p;
    endfunction

    function automatic int unsigned gpow(input int unsigned x, input int unsigned e,
                                         input int n, input int unsigned poly);
        int unsigned r = 1;
        for (int unsigned i = 0; i < e; i++) r = gmul(r, x, n, poly);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && b6.out_valid === 1'b1 && b6.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got y=%0h, expected no result", b6.y);
            end else begin
                check("scoreboard_y", 32'(b6.y), sb.pop_front());
            end
        end
    end

    task automatic wait_ready6();
        int w = 0;
        while (b6.in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 50) check("in_ready_timeout", 32'(b6.in_ready), 32'd1);
    endtask

    // Accept one op, check latency; with out_ready high, also check the return to IDLE.
    task automatic do_op(input logic [5:0] xv, input logic [5:0] ev, input logic [5:0] yv,
                         input string tag);
        int lat = 0;
        wait_ready6();
        b6.x = xv; b6.e = ev; b6.in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(32'(yv));
        #1 b6.in_valid = 1'b0;
        while (lat < 16) begin
            @(posedge clk); #1; lat++;
            if (b6.out_valid === 1'b1) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'd6);
        if (b6.out_ready === 1'b1) begin
            @(posedge clk); #1;
            check({tag, "_idle"}, {30'd0, b6.out_valid, b6.in_ready}, 32'b01);
        end
    endtask

    task automatic do_op8(input logic [7:0] xv, input logic [7:0] ev, input logic [7:0] yv,
                          input string tag);
        int lat = 0;
        b8.x = xv; b8.e = ev; b8.in_valid = 1'b1;
        @(posedge clk);
        #1 b8.in_valid = 1'b0;
        while (lat < 20) begin
            @(posedge clk); #1; lat++;
            if (b8.out_valid === 1'b1) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_y"}, 32'(b8.y), 32'(yv));
        @(posedge clk); #1;
        check({tag, "_idle"}, {30'd0, b8.out_valid, b8.in_ready}, 32'b01);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vt[0] = '{6'h02, 6'd6,  6'h03};
        vt[1] = '{6'h02, 6'd7,  6'h06};
        vt[2] = '{6'h03, 6'd2,  6'h05};
        vt[3] = '{6'h02, 6'd62, 6'h21};
        vt[4] = '{6'h02, 6'd63, 6'h01};
        vt[5] = '{6'h00, 6'd0,  6'h01};
        vt[6] = '{6'h00, 6'd5,  6'h00};

        rst = 1'b1;
        b6.in_valid = 1'b1; b6.x = 6'h02; b6.e = 6'd6; b6.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.x = '0; b8.e = '0; b8.out_ready = 1'b1;
        drv_done = 1'b0;

        // Reset with a pulse on in_valid that must not be taken
        @(posedge clk); #1 b6.in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_in_ready", 32'(b6.in_ready), 32'd1);
        check("rst_out_valid", 32'(b6.out_valid), 32'd0);
        check("rst_y", 32'(b6.y), 32'd0);
        check("rst_y8", 32'(b8.y), 32'd0);
        repeat (8) @(posedge clk);
        #1 check("rst_no_accept", {30'd0, b6.out_valid, b6.in_ready}, 32'b01);

        for (int i = 0; i < 7; i++) do_op(vt[i].x, vt[i].e, vt[i].y, $sformatf("vec%0d", i));

        // Backpressure: result held while out_ready is low
        b6.out_ready = 1'b0;
        do_op(6'h02, 6'd6, 6'h03, "bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {24'd0, b6.out_valid, b6.in_ready, b6.y}, {24'd0, 2'b10, 6'h03});
        end
        b6.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {30'd0, b6.out_valid, b6.in_ready}, 32'b01);

        // Reset in the middle of RUN discards the operation
        wait_ready6();
        b6.x = 6'h02; b6.e = 6'd62; b6.in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(32'h21);
        #1 b6.in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_state", {30'd0, b6.out_valid, b6.in_ready}, 32'b01);
        check("midrst_y", 32'(b6.y), 32'd0);
        rst = 1'b0;
        sb.delete();
        repeat (8) @(posedge clk);
        #1 check("midrst_no_result", 32'(b6.out_valid), 32'd0);
        do_op(6'h03, 6'd2, 6'h05, "after_rst");

        // 8-bit AES field instance
        do_op8(8'h53, 8'd254, 8'hCA, "aes_inv");
        do_op8(8'h02, 8'd8, 8'(gpow(2, 8, 8, 32'h11B)), "aes_x8");
        do_op8(8'h00, 8'd0, 8'h01, "aes_zero_pow0");

        // Random operands with random input gaps and output backpressure
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int unsigned xi, ei;
                    int w;
                    xi = $urandom_range(0, 63);
                    ei = $urandom_range(0, 63);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    b6.x = 6'(xi); b6.e = 6'(ei); b6.in_valid = 1'b1;
                    w = 0;
                    forever begin
                        @(negedge clk);
                        if (b6.in_ready === 1'b1) break;
                        w++;
                        if (w > 100) break;
                    end
                    if (w > 100) begin
                        check("rand_accept_timeout", 32'(b6.in_ready), 32'd1);
                        break;
                    end
                    @(posedge clk);
                    sb.push_back(gpow(xi, ei, 6, 32'h43));
                    #1 b6.in_valid = 1'b0;
                end
                drv_done = 1'b1;
            end
            begin
                int cyc = 0;
                while ((!drv_done || sb.size() > 0) && cyc < 60000) begin
                    @(posedge clk); #1;
                    b6.out_ready = ($urandom_range(0, 3) != 0);
                    cyc++;
                end
                if (cyc >= 60000) check("rand_drain_timeout", 32'(sb.size()), 32'd0);
            end
        join
        b6.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
